// File: rtl/band_frame_arbiter.sv
// Round-robin arbiter that loads one generator's frame into an LED band driver, then enforces an idle gap.
// Optional build macro PRIO_URGENT_EN: req[2] always wins, req[0]/req[1] share round-robin.
module band_frame_arbiter #(
  parameter int NUM_LEDS  = 60,
  parameter int FRAME_GAP = 1000,
  parameter int BUSY_TMO  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  output logic [2:0]  gnt,
  output logic [5:0]  pix_addr,
  input  logic [23:0] pix_data0,
  input  logic [23:0] pix_data1,
  input  logic [23:0] pix_data2,
  output logic [2:0]  frame_done,
  output logic [5:0]  drv_addr,
  output logic [23:0] drv_data,
  output logic        drv_wen,
  input  logic        drv_busy,
  output logic        err_tmo
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, SEND, GAP} state_t;

  localparam logic [5:0]  LAST_ADDR = 6'(NUM_LEDS);
  localparam logic [15:0] GAP_LAST  = 16'(FRAME_GAP - 1);
  localparam logic [15:0] TMO_LAST  = 16'(BUSY_TMO - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [1:0]  last_idx, pick_idx;
  logic [2:0]  pick_gnt;

  // Winner among the current requests; only consumed in IDLE when req is non-zero.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    pick_idx = 2'd0;
`ifdef PRIO_URGENT_EN
    if (req[2])
      pick_idx = 2'd2;
    else if (req[0] && (!req[1] || last_idx != 2'd0))
      pick_idx = 2'd0;
    else
      pick_idx = 2'd1;
`else
    case (last_idx)
      2'd0:    pick_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
`endif
    pick_gnt = 3'b001 << pick_idx;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|req) state_nxt = LOAD;
      LOAD:      if (drv_addr == LAST_ADDR) state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (drv_busy) state_nxt = SEND;
                 else if (cnt == TMO_LAST) state_nxt = GAP;
      SEND:      if (!drv_busy) state_nxt = GAP;
      GAP:       if (cnt == GAP_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // One counter serves both the busy timeout and the inter-frame gap; it is zero on entry to each.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt        <= '0;
      last_idx   <= 2'd2;
      drv_addr   <= '0;
      drv_wen    <= 1'b0;
      cnt        <= '0;
      frame_done <= '0;
      err_tmo    <= 1'b0;
    end else begin
      frame_done <= '0;
      case (state)
        IDLE: if (|req) begin
          gnt      <= pick_gnt;
          last_idx <= pick_idx;
          drv_addr <= 6'd1;
          drv_wen  <= 1'b1;
        end
        LOAD: if (drv_addr == LAST_ADDR) begin
          drv_addr <= '0;
          drv_wen  <= 1'b0;
        end else begin
          drv_addr <= drv_addr + 6'd1;
        end
        WAIT_BUSY: if (drv_busy) begin
          cnt <= '0;
        end else if (cnt == TMO_LAST) begin
          cnt     <= '0;
          err_tmo <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
        SEND: if (!drv_busy) frame_done <= gnt;
        GAP: if (cnt == GAP_LAST) begin
          cnt <= '0;
          gnt <= '0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign pix_addr = drv_addr;

  // Zero-latency data path: the granted generator answers for pix_addr in the same cycle.
  always_comb begin
    drv_data = '0;
    if (gnt[0])      drv_data = pix_data0;
    else if (gnt[1]) drv_data = pix_data1;
    else if (gnt[2]) drv_data = pix_data2;
  end

endmodule

// File: tb/tb_band_frame_arbiter.sv
// Self-checking bench for band_frame_arbiter: a frame-level procedural model plus directed literal checks.
// Honours PRIO_URGENT_EN when the design is built with it.
module tb_band_frame_arbiter;

  localparam int NUM_LEDS  = 60;
  localparam int FRAME_GAP = 1000;
  localparam int BUSY_TMO  = 16;

  logic        clk, reset, drv_busy;
  logic [2:0]  req, gnt, frame_done;
  logic [5:0]  pix_addr, drv_addr;
  logic [23:0] pix_data0, pix_data1, pix_data2, drv_data;
  logic        drv_wen, err_tmo;

  int checks = 0;
  int errors = 0;

  band_frame_arbiter #(.NUM_LEDS(NUM_LEDS), .FRAME_GAP(FRAME_GAP), .BUSY_TMO(BUSY_TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .pix_addr(pix_addr),
    .pix_data0(pix_data0), .pix_data1(pix_data1), .pix_data2(pix_data2),
    .frame_done(frame_done), .drv_addr(drv_addr), .drv_data(drv_data),
    .drv_wen(drv_wen), .drv_busy(drv_busy), .err_tmo(err_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each generator paints a distinct, address-dependent colour.
  function automatic logic [23:0] gen_data(input int g, input logic [5:0] a);
    case (g)
      0:       return {2'b00, a, 8'hA5, 2'b00, a};
      1:       return {2'b00, a, 2'b00, a, 2'b00, a};
      default: return {8'h5A, 2'b00, a, 8'hC3};
    endcase
  endfunction

  assign pix_data0 = gen_data(0, pix_addr);
  assign pix_data1 = gen_data(1, pix_addr);
  assign pix_data2 = gen_data(2, pix_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] exp_gnt, exp_done;
  logic [5:0] exp_addr;
  logic       exp_wen, exp_err;
  int         m_last;

  function automatic int model_pick(input logic [2:0] r, input int last);
`ifdef PRIO_URGENT_EN
    if (r[2]) return 2;
    if (r[1:0] == 2'b11) return (last == 0) ? 1 : 0;
    return r[0] ? 0 : 1;
`else
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return 0;
`endif
  endfunction

  // One call walks an IDLE cycle and, if a request is seen, the whole frame; returns early on reset.
  task automatic model_frame();
    int  g, w;
    bit  busy_seen;
    exp_gnt = '0; exp_addr = '0; exp_wen = 1'b0; exp_done = '0;
    @(posedge clk); if (reset !== 1'b1) return;
    if (req == 3'b000) return;
    g = model_pick(req, m_last);
    m_last = g;
    exp_gnt = 3'b001 << g; exp_addr = 6'd1; exp_wen = 1'b1;
    for (int a = 2; a <= NUM_LEDS + 1; a++) begin
      @(posedge clk); if (reset !== 1'b1) return;
      if (a <= NUM_LEDS) exp_addr = 6'(a);
      else begin exp_addr = '0; exp_wen = 1'b0; end
    end
    w = 0; busy_seen = 0;
    forever begin
      @(posedge clk); if (reset !== 1'b1) return;
      if (drv_busy) begin busy_seen = 1; break; end
      w++;
      if (w == BUSY_TMO) begin exp_err = 1'b1; break; end
    end
    if (busy_seen) begin
      forever begin
        @(posedge clk); if (reset !== 1'b1) return;
        if (!drv_busy) break;
      end
      exp_done = exp_gnt;
    end
    for (int i = 0; i < FRAME_GAP; i++) begin
      @(posedge clk); if (reset !== 1'b1) return;
      exp_done = '0;
    end
    exp_gnt = '0;
  endtask

  initial begin
    forever begin
      if (reset !== 1'b1) begin
        exp_gnt = '0; exp_addr = '0; exp_wen = 1'b0; exp_done = '0; exp_err = 1'b0; m_last = 2;
        wait (reset === 1'b1);
      end
      model_frame();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    int gi;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        check("outputs_in_reset", {gnt, pix_addr, frame_done, drv_addr, drv_data, drv_wen, err_tmo}, '0);
      end else begin
        gi = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
        check("gnt", gnt, exp_gnt);
        check("gnt_onehot", ($countones(gnt) <= 1), 1);
        check("drv_addr", drv_addr, exp_addr);
        check("pix_addr", pix_addr, exp_addr);
        check("drv_wen", drv_wen, exp_wen);
        check("frame_done", frame_done, exp_done);
        check("err_tmo", err_tmo, exp_err);
        check("drv_data", drv_data, (exp_gnt == 3'b000) ? 24'h0 : gen_data(gi, exp_addr));
      end
    end
  end

  // ---------------- band driver model ----------------
  int dly_lo = 0, dly_hi = 10, bsy_lo = 1, bsy_hi = 8;
  bit never_busy = 0, noise_en = 0;

  initial begin
    logic prev_wen;
    prev_wen = 1'b0;
    drv_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && drv_wen && noise_en) begin
        drv_busy = ($urandom_range(0, 3) == 0);
      end else if (reset === 1'b1 && prev_wen && !drv_wen) begin
        drv_busy = 1'b0;
        if (!never_busy) begin
          repeat ($urandom_range(dly_lo, dly_hi)) @(negedge clk);
          drv_busy = 1'b1;
          repeat ($urandom_range(bsy_lo, bsy_hi)) @(negedge clk);
          drv_busy = 1'b0;
        end
      end else begin
        drv_busy = 1'b0;
      end
      prev_wen = drv_wen;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_wen(input string nm);
    int i = 0;
    while (drv_wen !== 1'b1 && i < 3000) begin @(negedge clk); i++; end
    check(nm, (drv_wen === 1'b1), 1);
  endtask

  task automatic wait_idle(input string nm);
    int i = 0;
    while (gnt !== 3'b000 && i < 3000) begin @(negedge clk); i++; end
    check(nm, (gnt === 3'b000), 1);
  endtask

  task automatic count_writes(input string nm);
    int n = 0;
    while (drv_wen === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check(nm, n, NUM_LEDS);
  endtask

  initial begin
    logic [2:0] order [4];
    int         n;
    logic [2:0] done_seen;

`ifdef PRIO_URGENT_EN
    order = '{3'b100, 3'b100, 3'b100, 3'b100};
`else
    order = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    reset = 1'b0;
    req   = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_gnt", gnt, 3'b000);
    check("reset_err", err_tmo, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Held 111: grant rotation and 60 writes per frame.
    req = 3'b111;
    for (int f = 0; f < 4; f++) begin
      wait_wen($sformatf("frame%0d_start", f));
      check($sformatf("grant_order%0d", f), gnt, order[f]);
      check($sformatf("first_addr%0d", f), drv_addr, 6'd1);
      if (f == 3) req = 3'b000;
      count_writes($sformatf("writes%0d", f));
    end
    wait_idle("idle_after_rotation");

    // Zero-skew data from generator 1.
    req = 3'b010;
    wait_wen("data_frame_start");
    check("data_addr1", drv_data, 24'h010101);
    n = 0;
    while (drv_addr !== 6'd60 && n < 100) begin @(negedge clk); n++; end
    check("data_addr60", drv_data, 24'h3C3C3C);
    req = 3'b000;
    wait_idle("idle_after_data");

    // Driver never responds: timeout 16 cycles after the write burst, no completion pulse.
    never_busy = 1;
    req = 3'b001;
    wait_wen("tmo_frame_start");
    req = 3'b000;
    count_writes("tmo_writes");
    n = 0;
    while (err_tmo !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("tmo_latency", n, 16);
    check("tmo_gnt_held", gnt, 3'b001);
    done_seen = '0;
    n = 0;
    while (gnt !== 3'b000 && n < 3000) begin done_seen |= frame_done; @(negedge clk); n++; end
    check("tmo_no_done", done_seen, 3'b000);
    check("tmo_sticky", err_tmo, 1'b1);
    never_busy = 0;

    // One-cycle request pulse: full frame, 4 wait + 5 busy cycles, then FRAME_GAP.
    dly_lo = 3; dly_hi = 3; bsy_lo = 5; bsy_hi = 5;
    @(negedge clk);
    req = 3'b001;
    @(negedge clk);
    req = 3'b000;
    n = 0; done_seen = '0;
    while (gnt !== 3'b000 && n < 3000) begin n++; done_seen |= frame_done; @(negedge clk); end
    check("pulse_frame_cycles", n, NUM_LEDS + 4 + 5 + FRAME_GAP);
    check("pulse_done", done_seen, 3'b001);

    // Reset in the middle of a load.
    dly_lo = 0; dly_hi = 10; bsy_lo = 1; bsy_hi = 8;
    req = 3'b100;
    n = 0;
    while (drv_addr !== 6'd30 && n < 3000) begin @(negedge clk); n++; end
    check("reached_addr30", drv_addr, 6'd30);
    #1 reset = 1'b0;
    #1 check("async_reset_outputs",
             {gnt, pix_addr, frame_done, drv_addr, drv_data, drv_wen, err_tmo}, '0);
    repeat (2) @(negedge clk);
    req = 3'b011;
    reset = 1'b1;
    wait_wen("post_reset_start");
    check("post_reset_gnt", gnt, 3'b001);
    req = 3'b000;
    wait_idle("idle_after_reset");

    // Random requests, driver timing and busy noise during the load.
    noise_en = 1; dly_lo = 0; dly_hi = 20; bsy_lo = 1; bsy_hi = 10;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
    end
    req = 3'b000;
    wait_idle("idle_after_random");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
